// File: rtl/approx_fp_div_pkg.sv
// approx_fp_div shared types: word layout, FSM states, tier iteration table.
// Imported by the divider, its pack stage and the handshake interface.
package approx_fp_pkg;

    localparam int N    = 32;
    localparam int E    = 8;
    localparam int M    = 23;
    localparam int BIAS = 127;

    localparam int SIGN = 31;
    localparam int EXP  = 30;
    localparam int MAN  = 22;

    localparam logic [N-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [N-2:0] INF  = 31'h7F80_0000;

    localparam logic [4:0] IT_T0 = 5'd1;
    localparam logic [4:0] IT_T1 = 5'd8;
    localparam logic [4:0] IT_T2 = 5'd16;
    localparam logic [4:0] IT_T3 = 5'd26;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic logic [4:0] tier_iters(input logic [1:0] t);
        logic [4:0] n;
        unique case (t)
            2'd0: n = IT_T0;
            2'd1: n = IT_T1;
            2'd2: n = IT_T2;
            2'd3: n = IT_T3;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/approx_fp_div_if.sv
// Valid/ready operand and result bundle for approx_fp_div.
// master feeds operands and consumes results; slave is the divider.
interface approx_fp_div_if;
    import approx_fp_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   t;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] y;
    logic         div_by_zero;

    modport master (
        output in_valid, a, b, t, out_ready,
        input  in_ready, out_valid, y, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, t, out_ready,
        output in_ready, out_valid, y, div_by_zero
    );

endinterface

// File: rtl/approx_fp_div_pack.sv
// fp_div_pack: combinational normalize, RNE round, range check and field pack
// for a divider quotient (Mitchell fraction for tier 0, restoring q otherwise).
module fp_div_pack
    import approx_fp_pkg::*;
(
    input  logic         sgn,
    input  logic [E-1:0] ea,
    input  logic [E-1:0] eb,
    input  logic [M-1:0] fa,
    input  logic [M-1:0] fb,
    input  logic [1:0]   t,
    input  logic [25:0]  q,
    input  logic         sticky,
    output logic [N-1:0] y,
    output logic         dbz
);

    logic              a_zero;
    logic              b_zero;
    logic              nan_in;
    logic              norm;
    logic              up;
    logic              cy;
    logic [24:0]       qn;
    logic [M-1:0]      man;
    logic [M:0]        rnd;
    logic [9:0]        e_raw;
    logic signed [9:0] e;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign nan_in = (ea == '1) || (eb == '1);

    always_comb begin
        norm = 1'b0;
        qn   = '0;
        up   = 1'b0;
        rnd  = '0;
        man  = '0;
        cy   = 1'b0;
        if (t == 2'd0) begin
            norm = (fa < fb);
            man  = fa - fb;
        end else begin
            // q[25] is the integer bit; a zero there costs one exponent step
            norm = !q[25];
            qn   = norm ? {q[23:0], 1'b0} : q[24:0];
            up   = (t == 2'd3) && qn[1] && (qn[0] || sticky || qn[2]);
            rnd  = {1'b0, qn[24:2]} + {{M{1'b0}}, up};
            man  = rnd[M-1:0];
            cy   = rnd[M];
        end
        e_raw = 10'(ea) - 10'(eb) + 10'(BIAS) - 10'(norm) + 10'(cy);
        e     = $signed(e_raw);
    end

    always_comb begin
        y   = '0;
        dbz = 1'b0;
        if (nan_in || (a_zero && b_zero)) begin
            y = QNAN;
        end else if (a_zero) begin
            y = {sgn, 31'd0};
        end else if (b_zero) begin
            y   = {sgn, INF};
            dbz = 1'b1;
        end else if (e >= 10'sd255) begin
            y = {sgn, INF};
        end else if (e <= 10'sd0) begin
            y = {sgn, 31'd0};
        end else begin
            y = {sgn, e[7:0], man};
        end
    end

endmodule

// File: rtl/approx_fp_div.sv
// approx_fp_div: tiered multi-cycle FP32 divider (Mitchell / restoring).
// Define APPROX_FP_DIV_EARLY_TERM_EN to leave CALC once the remainder hits 0.
module approx_fp_div
    import approx_fp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    approx_fp_div_if.slave io
);

    state_t       state;
    state_t       state_nx;
    logic [4:0]   cnt;
    logic [4:0]   n;
    logic         sgn;
    logic [E-1:0] ea;
    logic [E-1:0] eb;
    logic [M-1:0] fa;
    logic [M-1:0] fb;
    logic [1:0]   t;
    logic [24:0]  rem;
    logic [24:0]  rem_nx;
    logic [24:0]  mb;
    logic [25:0]  q;
    logic [25:0]  q_nx;
    logic         qbit;
    logic         last;
    logic         accept;
    logic         step;
    logic         pack;
    logic [E-1:0] a_exp;
    logic [E-1:0] b_exp;
    logic         special;
    logic [N-1:0] y_q;
    logic [N-1:0] y_pk;
    logic         dbz_q;
    logic         dbz_pk;

    assign a_exp   = io.a[EXP -: E];
    assign b_exp   = io.b[EXP -: E];
    assign special = (a_exp == '0) || (b_exp == '0)
                  || (a_exp == '1) || (b_exp == '1);
    assign accept  = io.in_valid && io.in_ready;
    assign mb      = {1'b0, |eb, fb};

    always_comb begin
        qbit   = (rem >= mb);
        rem_nx = (rem - (qbit ? mb : 25'd0)) << 1;
        q_nx   = q | (26'(qbit) << (5'd25 - cnt));
    end

`ifdef APPROX_FP_DIV_EARLY_TERM_EN
    assign last = (cnt == n)
               || ((t != 2'd0) && (cnt != '0) && (rem == '0));
`else
    assign last = (cnt == n);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (io.in_valid)  state_nx = CALC;
            CALC:    if (last)         state_nx = DONE;
            DONE:    if (io.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        step         = 1'b0;
        pack         = 1'b0;
        unique case (state)
            IDLE: io.in_ready = 1'b1;
            CALC: begin
                step = !last;
                pack = last;
            end
            DONE: io.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            n     <= '0;
            sgn   <= 1'b0;
            ea    <= '0;
            eb    <= '0;
            fa    <= '0;
            fb    <= '0;
            t     <= '0;
            rem   <= '0;
            q     <= '0;
            y_q   <= '0;
            dbz_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
                n   <= special ? IT_T0 : tier_iters(io.t);
                sgn <= io.a[SIGN] ^ io.b[SIGN];
                ea  <= a_exp;
                eb  <= b_exp;
                fa  <= io.a[MAN -: M];
                fb  <= io.b[MAN -: M];
                t   <= io.t;
                rem <= {1'b0, |a_exp, io.a[MAN -: M]};
                q   <= '0;
            end else if (step) begin
                cnt <= cnt + 5'd1;
                rem <= rem_nx;
                q   <= q_nx;
            end
            if (pack) begin
                y_q   <= y_pk;
                dbz_q <= dbz_pk;
            end
        end
    end

    fp_div_pack u_pack (
        .sgn    (sgn),
        .ea     (ea),
        .eb     (eb),
        .fa     (fa),
        .fb     (fb),
        .t      (t),
        .q      (q),
        .sticky (rem != '0),
        .y      (y_pk),
        .dbz    (dbz_pk)
    );

    assign io.y           = y_q;
    assign io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_approx_fp_div.sv
// Scoreboard bench for approx_fp_div: directed cases, backpressure, reset abort
// and randomized operands against an arithmetic reference model.
module tb_approx_fp_div;
    import approx_fp_pkg::*;

    typedef struct packed {
        logic [31:0] y;
        logic        dbz;
        int          lat;
        longint      ta;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    approx_fp_div_if io();

    approx_fp_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    exp_t   sb[$];
    exp_t   ent;
    int     checks = 0;
    int     failures = 0;
    int     mode = 0;
    int     id_n = 0;
    int     mlat;
    bit     seen = 0;
    longint tr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Reference: quotient bits from integer division of the significands
    function automatic void ref_model(input logic [31:0] a, b,
                                      input logic [1:0] t,
                                      output logic [31:0] y,
                                      output logic dbz, output int lat);
        logic        s;
        int          ea, eb, e, n, k;
        logic [23:0] ma, mb, m;
        logic [22:0] fr;
        logic [25:0] q;
        longint      num, qf, rm;
        bit          up;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        ma  = {1'b1, a[22:0]};
        mb  = {1'b1, b[22:0]};
        dbz = 1'b0;
        lat = 2;
        y   = '0;
        m   = '0;
        if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
            y = QNAN;
            return;
        end
        if (ea == 0) begin
            y = {s, 31'd0};
            return;
        end
        if (eb == 0) begin
            y   = {s, INF};
            dbz = 1'b1;
            return;
        end
        e = ea - eb + 127;
        if (t == 2'd0) begin
            fr = a[22:0] - b[22:0];
            if (a[22:0] < b[22:0]) e--;
            m = {1'b0, fr};
        end else begin
            n   = (t == 2'd1) ? 8 : (t == 2'd2) ? 16 : 26;
            num = longint'(ma) << 25;
            qf  = num / longint'(mb);
            rm  = num % longint'(mb);
            q   = 26'(qf);
            q   = (q >> (26 - n)) << (26 - n);
            lat = n + 1;
`ifdef APPROX_FP_DIV_EARLY_TERM_EN
            k = 1;
            while (k < n && ((longint'(ma) << (k - 1)) % longint'(mb)) != 0)
                k++;
            lat = k + 1;
`else
            k = n;
`endif
            if (!q[25]) begin
                q = q << 1;
                e--;
            end
            up = (t == 2'd3) && q[1] && (q[0] || rm != 0 || q[2]);
            m  = {1'b0, q[24:2]} + 24'(up);
            if (m[23]) e++;
        end
        if (e >= 255)    y = {s, INF};
        else if (e <= 0) y = {s, 31'd0};
        else             y = {s, 8'(e), m[22:0]};
    endfunction

    task automatic issue(input logic [31:0] aa, bb, input logic [1:0] tt,
                         input logic [31:0] ey, input logic ed,
                         input int el, input bit push);
        int   w;
        exp_t x;
        w = 0;
        @(negedge clk);
        io.a        = aa;
        io.b        = bb;
        io.t        = tt;
        io.in_valid = 1'b1;
        while (!io.in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!io.in_ready) begin
            fail("accept_timeout");
            io.in_valid = 1'b0;
            return;
        end
        if (push) begin
            x.y   = ey;
            x.dbz = ed;
            x.lat = el;
            x.ta  = longint'($time) + 5;
            x.id  = id_n;
            sb.push_back(x);
        end
        id_n++;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.a        = $urandom;
        io.b        = $urandom;
    endtask

    task automatic dir(input logic [31:0] aa, bb, input logic [1:0] tt,
                       input logic [31:0] ey, input logic ed, input int el);
`ifdef APPROX_FP_DIV_EARLY_TERM_EN
        logic [31:0] my;
        logic        md;
        int          ml;
        ref_model(aa, bb, tt, my, md, ml);
        el = ml;
`endif
        issue(aa, bb, tt, ey, ed, el, 1'b1);
    endtask

    task automatic go(input logic [31:0] aa, bb, input logic [1:0] tt);
        logic [31:0] ey;
        logic        ed;
        int          el;
        ref_model(aa, bb, tt, ey, ed, el);
        issue(aa, bb, tt, ey, ed, el, 1'b1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            fail("drain_timeout");
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        io.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       io.out_ready = ($urandom_range(0, 3) != 0);
                1:       io.out_ready = 1'b0;
                default: io.out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && io.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    tr   = longint'($time) - 5;
                end
                if (io.out_ready) begin
                    if (sb.size() == 0) begin
                        fail("unexpected_output");
                    end else begin
                        ent = sb.pop_front();
                        chk($sformatf("y_op%0d", ent.id), io.y, ent.y);
                        chk($sformatf("dbz_op%0d", ent.id),
                            32'(io.div_by_zero), 32'(ent.dbz));
                        mlat = int'((tr - ent.ta) / 10);
                        chk($sformatf("latency_op%0d", ent.id),
                            mlat, ent.lat);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [31:0] ra, rb;
        logic [1:0]  rt;
        int          k;
        io.in_valid = 1'b0;
        io.a        = '0;
        io.b        = '0;
        io.t        = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_y", io.y, 32'd0);
        chk("rst_dbz", 32'(io.div_by_zero), 32'd0);
        chk("rst_in_ready", 32'(io.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(io.in_ready), 32'd1);

        mode = 0;
        dir(32'h40400000, 32'h40000000, 2'd3, 32'h3FC00000, 1'b0, 27);
        dir(32'h40400000, 32'h40000000, 2'd0, 32'h3FC00000, 1'b0, 2);
        dir(32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAB, 1'b0, 27);
        dir(32'h3F800000, 32'h40400000, 2'd1, 32'h3EAA0000, 1'b0, 9);
        dir(32'h3F800000, 32'h40400000, 2'd2, 32'h3EAAAA00, 1'b0, 17);
        dir(32'h3F800000, 32'h40400000, 2'd0, 32'h3EC00000, 1'b0, 2);
        dir(32'h3F800000, 32'h00000000, 2'd3, 32'h7F800000, 1'b1, 2);
        dir(32'h80000000, 32'h3F800000, 2'd3, 32'h80000000, 1'b0, 2);
        dir(32'h00000000, 32'h00000000, 2'd1, 32'h7FC00000, 1'b0, 2);
        dir(32'h7F800000, 32'h3F800000, 2'd2, 32'h7FC00000, 1'b0, 2);
        dir(32'h7F000000, 32'h3E800000, 2'd3, 32'h7F800000, 1'b0, 27);
        dir(32'h00800000, 32'h4B000000, 2'd3, 32'h00000000, 1'b0, 27);
        wait_drain();

        // Hold the result under backpressure while a new request waits
        mode = 1;
        dir(32'h40400000, 32'h40000000, 2'd3, 32'h3FC00000, 1'b0, 27);
        w = 0;
        while (!io.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!io.out_valid) fail("stall_valid_timeout");
        io.a        = 32'h3F800000;
        io.b        = 32'h40400000;
        io.t        = 2'd0;
        io.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall_y_%0d", i), io.y, 32'h3FC00000);
            chk($sformatf("stall_valid_%0d", i), 32'(io.out_valid), 32'd1);
            chk($sformatf("stall_in_ready_%0d", i), 32'(io.in_ready), 32'd0);
        end
        io.in_valid = 1'b0;
        mode = 2;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (io.out_valid && w < 20);
        chk("post_release_in_ready", 32'(io.in_ready), 32'd1);
        mode = 0;

        for (int i = 0; i < 80; i++) begin
            k  = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            rt = 2'($urandom);
            if (k < 7) begin
                ra[30:23] = 8'($urandom_range(64, 190));
                rb[30:23] = 8'($urandom_range(64, 190));
            end else if (k == 7) begin
                if ($urandom_range(0, 1) == 0) ra[30:23] = 8'd0;
                else                           rb[30:23] = 8'd0;
            end else if (k == 8) begin
                rb[22:0] = ra[22:0];
            end
            go(ra, rb, rt);
        end
        wait_drain();

        dir(32'h3F800000, 32'h40400000, 2'd1, 32'h3EAA0000, 1'b0, 9);
        wait_drain();
        issue(32'h3F800000, 32'h40400000, 2'd3, 32'h0, 1'b0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(io.out_valid), 32'd0);
        chk("abort_y", io.y, 32'd0);
        chk("abort_dbz", 32'(io.div_by_zero), 32'd0);
        seen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(io.in_ready), 32'd1);
        dir(32'h40400000, 32'h40000000, 2'd0, 32'h3FC00000, 1'b0, 2);
        dir(32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAB, 1'b0, 27);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
